run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run controller: turns a start edge into a one-cycle core reset/PC load,
// then enables the core until it halts, reaches PC 0xFF, or times out.
module run_controller #(
  parameter logic [8:0] HALT_CODE      = 9'h1FF,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       start_addr,
  input  logic [8:0]       mach_code,
  input  logic [7:0]       pc,
  output logic             core_rst,
  output logic             pc_load,
  output logic [7:0]       pc_load_val,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic             start_q;
  logic             armed;
  logic             start_edge;
  logic             accept;
  logic             halt_hit;
  logic             timeout_hit;
  logic [CNT_W-1:0] count;
  logic             to_flag;

  // armed stays low after reset until start has been seen low, so a start
  // already high when reset is released cannot look like a fresh edge.
  assign start_edge  = start & ~start_q & armed;
  assign accept      = start_edge & ((state == IDLE) | (state == FIN));
  assign halt_hit    = (mach_code == HALT_CODE) | (pc == 8'hFF);
  assign timeout_hit = (count == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = INIT;
      INIT:    state_next = RUN;
      RUN:     if (halt_hit || timeout_hit) state_next = FIN;
      FIN:     if (accept) state_next = INIT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q     <= 1'b0;
      armed       <= 1'b0;
      pc_load_val <= '0;
      count       <= '0;
      to_flag     <= 1'b0;
    end else begin
      start_q <= start;
      armed   <= armed | ~start;
      if (accept) begin
        pc_load_val <= start_addr;
        count       <= '0;
        to_flag     <= 1'b0;
      end else if (state == RUN) begin
        // The halting cycle is counted; a halt on the last allowed cycle wins.
        if (count != '1) count <= count + CNT_W'(1);
        if (!halt_hit && timeout_hit) to_flag <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    core_rst = 1'b0;
    pc_load  = 1'b0;
    core_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      INIT: begin
        core_rst = 1'b1;
        pc_load  = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        core_en = 1'b1;
        busy    = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign cycle_count = count;
  assign timed_out   = to_flag;

endmodule
